// File: rtl/instr_decode_fsm.sv
// ----------------------------------------------------------------------------
// instr_decode_fsm
//
// Fetch/decode controller. It fetches 16-bit instruction words over a simple
// req/ack memory handshake and turns each one into the control word the
// regfile/ALU datapath already consumes: a one-hot regfile write enable,
// operand A/B register selects, an immediate select and the raw instruction
// word (op/imm fields) for the ALU.
//
// Instruction word: op=[15:12] rd=[11:8] ext=[7:4] rs=[3:0] imm=[7:0]
//   0x0000            NOP
//   0xFFFF            HALT
//   op=0x0 (not NOP)  register form   A=rd, B=rs
//   op=0x1..0xE       immediate form  A=rd, B=imm
//   op=0xF (not HALT) illegal
//
// Sequence: FETCH (>=1 cycle) -> DECODE (1) -> EXECUTE (1) -> FETCH ...
//           HALT is terminal until reset.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   o_mem_req      out  instruction fetch request
//   o_mem_addr     out  fetch address (= PC)
//   i_mem_ack      in   fetch data valid on i_mem_rdata this cycle
//   i_mem_rdata    in   instruction word
//   o_reg_enable   out  one-hot regfile write enable (bit n = rN)
//   o_mux_a        out  operand A register select
//   o_mux_b        out  operand B register select
//   o_mux_c        out  0 = B from register, 1 = B from immediate
//   o_alu_control  out  instruction word presented to the ALU
//   o_retire       out  one-cycle pulse per completed instruction
//   o_illegal      out  one-cycle pulse on an undefined opcode
//   o_halted       out  high while in HALT
//
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module instr_decode_fsm #(
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  BOOT_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [15:0]       i_mem_rdata,
  output logic [15:0]       o_reg_enable,
  output logic [3:0]        o_mux_a,
  output logic [3:0]        o_mux_b,
  output logic              o_mux_c,
  output logic [15:0]       o_alu_control,
  output logic              o_retire,
  output logic              o_illegal,
  output logic              o_halted
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  // Decoded view of the instruction register.
  typedef struct packed {
    logic       is_nop;
    logic       is_halt;
    logic       is_reg;
    logic       is_imm;
    logic       is_ill;
    logic [3:0] rd;
    logic [3:0] rs;
  } dec_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic              r_mem_req;
  logic [15:0]       r_reg_enable;
  logic [3:0]        r_mux_a;
  logic [3:0]        r_mux_b;
  logic              r_mux_c;
  logic [15:0]       r_alu_control;
  logic              r_retire;
  logic              r_illegal;
  logic              r_halted;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [15:0]       w_ir_nxt;
  logic              w_mem_req_nxt;
  logic [15:0]       w_reg_enable_nxt;
  logic [3:0]        w_mux_a_nxt;
  logic [3:0]        w_mux_b_nxt;
  logic              w_mux_c_nxt;
  logic [15:0]       w_alu_control_nxt;
  logic              w_retire_nxt;
  logic              w_illegal_nxt;
  logic              w_halted_nxt;

  dec_t              w_dec;

  // --------------------------------------------------------------------------
  // Instruction classification
  // --------------------------------------------------------------------------
  always_comb begin
    w_dec         = '0;
    w_dec.rd      = r_ir[11:8];
    w_dec.rs      = r_ir[3:0];
    w_dec.is_nop  = (r_ir == 16'h0000);
    w_dec.is_halt = (r_ir == 16'hFFFF);
    w_dec.is_reg  = (r_ir[15:12] == 4'h0) && !w_dec.is_nop;
    w_dec.is_imm  = (r_ir[15:12] != 4'h0) && (r_ir[15:12] != 4'hF);
    w_dec.is_ill  = (r_ir[15:12] == 4'hF) && !w_dec.is_halt;
  end

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Hold everything by default; the one-cycle pulses default low.
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_ir_nxt          = r_ir;
    w_mem_req_nxt     = r_mem_req;
    w_reg_enable_nxt  = '0;
    w_mux_a_nxt       = r_mux_a;
    w_mux_b_nxt       = r_mux_b;
    w_mux_c_nxt       = r_mux_c;
    w_alu_control_nxt = r_alu_control;
    w_retire_nxt      = 1'b0;
    w_illegal_nxt     = 1'b0;
    w_halted_nxt      = r_halted;

    unique case (r_state)
      S_FETCH: begin
        // Entering FETCH from EXECUTE already raises the request, so the
        // request is up in the first FETCH cycle. Only the first cycle out of
        // reset has it low; an ack is only meaningful with a request up.
        if (!r_mem_req) begin
          w_mem_req_nxt = 1'b1;
        end else if (i_mem_ack) begin
          w_ir_nxt      = i_mem_rdata;
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_DECODE;
        end
      end

      S_DECODE: begin
        if (w_dec.is_halt) begin
          // Controls keep their previous values; nothing is written.
          w_halted_nxt = 1'b1;
          w_state_nxt  = S_HALT;
        end else begin
          // Selects are loaded here so they are already stable in the
          // cycle the write enable fires, and hold until the next DECODE.
          w_mux_a_nxt       = w_dec.rd;
          w_mux_b_nxt       = w_dec.is_imm ? 4'h0 : w_dec.rs;
          w_mux_c_nxt       = w_dec.is_imm;
          w_alu_control_nxt = r_ir;
          // Pulses registered now so they are visible during EXECUTE.
          if (w_dec.is_reg || w_dec.is_imm)
            w_reg_enable_nxt = 16'h0001 << w_dec.rd;
          w_retire_nxt  = 1'b1;
          w_illegal_nxt = w_dec.is_ill;
          w_state_nxt   = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        // PC wraps silently at 2^ADDR_W.
        w_pc_nxt      = r_pc + ADDR_W'(1);
        w_mem_req_nxt = 1'b1;
        w_state_nxt   = S_FETCH;
      end

      S_HALT: begin
        w_mem_req_nxt = 1'b0;
        w_halted_nxt  = 1'b1;
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers. Reset has priority over a same-cycle ack.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_pc          <= BOOT_ADDR;
      r_ir          <= '0;
      r_mem_req     <= 1'b0;
      r_reg_enable  <= '0;
      r_mux_a       <= '0;
      r_mux_b       <= '0;
      r_mux_c       <= 1'b0;
      r_alu_control <= '0;
      r_retire      <= 1'b0;
      r_illegal     <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_ir          <= w_ir_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_reg_enable  <= w_reg_enable_nxt;
      r_mux_a       <= w_mux_a_nxt;
      r_mux_b       <= w_mux_b_nxt;
      r_mux_c       <= w_mux_c_nxt;
      r_alu_control <= w_alu_control_nxt;
      r_retire      <= w_retire_nxt;
      r_illegal     <= w_illegal_nxt;
      r_halted      <= w_halted_nxt;
    end
  end

  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_pc;
  assign o_reg_enable  = r_reg_enable;
  assign o_mux_a       = r_mux_a;
  assign o_mux_b       = r_mux_b;
  assign o_mux_c       = r_mux_c;
  assign o_alu_control = r_alu_control;
  assign o_retire      = r_retire;
  assign o_illegal     = r_illegal;
  assign o_halted      = r_halted;

endmodule

// File: tb/tb_instr_decode_fsm.sv
module tb_instr_decode_fsm;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] reg_en;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        c;
    logic [15:0] alu;
    logic        ill;
    int          gap;   // required cycles since previous retire, 0 = skip
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] reg_enable;
  logic [3:0]  mux_a, mux_b;
  logic        mux_c;
  logic [15:0] alu_control;
  logic        retire, illegal, halted;

  // second instance: 4-bit PC booting at 15 for the wrap check
  logic        b_reset = 1'b1;
  logic        b_req;
  logic [3:0]  b_addr;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic [15:0] b_reg_enable;
  logic [3:0]  b_mux_a, b_mux_b;
  logic        b_mux_c;
  logic [15:0] b_alu;
  logic        b_retire, b_illegal, b_halted;

  // memory responder state
  logic [15:0] mem [0:15];
  int          ack_delay = 0;
  bit          spurious  = 1'b0;
  logic        resp_ack  = 1'b0;
  logic [15:0] resp_rdata = '0;
  logic        ovr_ack   = 1'b0;
  logic [15:0] ovr_rdata = '0;
  int          wcnt = 0;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_ret = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_ack   = resp_ack | ovr_ack;
  assign mem_rdata = ovr_ack ? ovr_rdata : resp_rdata;
  assign b_ack     = b_req;
  assign b_rdata   = 16'h5102;

  instr_decode_fsm #(.ADDR_W(16), .BOOT_ADDR(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_reg_enable(reg_enable), .o_mux_a(mux_a), .o_mux_b(mux_b),
    .o_mux_c(mux_c), .o_alu_control(alu_control),
    .o_retire(retire), .o_illegal(illegal), .o_halted(halted)
  );

  instr_decode_fsm #(.ADDR_W(4), .BOOT_ADDR(4'hF)) dut_w (
    .clk(clk), .reset(b_reset),
    .o_mem_req(b_req), .o_mem_addr(b_addr),
    .i_mem_ack(b_ack), .i_mem_rdata(b_rdata),
    .o_reg_enable(b_reg_enable), .o_mux_a(b_mux_a), .o_mux_b(b_mux_b),
    .o_mux_c(b_mux_c), .o_alu_control(b_alu),
    .o_retire(b_retire), .o_illegal(b_illegal), .o_halted(b_halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: answers a request after ack_delay wait cycles; drives a junk
  // word with ack when spurious is set and no request is up.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (wcnt == ack_delay) begin
        resp_ack   = 1'b1;
        resp_rdata = mem[mem_addr[3:0]];
      end else begin
        resp_ack   = 1'b0;
        resp_rdata = 16'hDEAD;
      end
      wcnt++;
    end else begin
      wcnt       = 0;
      resp_ack   = spurious;
      resp_rdata = 16'hF123;
    end
  end

  // Monitor / scoreboard: every retire pulse pops one expected instruction.
  always @(negedge clk) begin
    if (!reset && retire) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ret_pc",     mem_addr,    e.pc);
        chk("ret_reg_en", reg_enable,  e.reg_en);
        chk("ret_mux_a",  mux_a,       e.a);
        chk("ret_mux_b",  mux_b,       e.b);
        chk("ret_mux_c",  mux_c,       e.c);
        chk("ret_alu",    alu_control, e.alu);
        chk("ret_illegal", illegal,    e.ill);
        if (e.gap != 0) chk("ret_gap", cyc - last_ret, e.gap);
      end
      last_ret = cyc;
    end
  end

  task automatic push(input logic [15:0] pc, input logic [15:0] re, input logic [3:0] a,
                      input logic [3:0] b, input logic c, input logic [15:0] alu,
                      input logic ill, input int gap);
    exp_t e;
    e.pc = pc; e.reg_en = re; e.a = a; e.b = b; e.c = c; e.alu = alu; e.ill = ill; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_rst_req"},    mem_req, 0);
    chk({tag, "_rst_addr"},   mem_addr, 0);
    chk({tag, "_rst_ctrl"},   {reg_enable, mux_a, mux_b, 3'b0, mux_c}, 0);
    chk({tag, "_rst_alu"},    alu_control, 0);
    chk({tag, "_rst_pulses"}, {retire, illegal, halted}, 0);
    reset = 1'b0;
  endtask

  // Runs until halted; reports the last fetch-ack cycle, halt cycle,
  // address stability while a request is up and wait-length mismatches.
  task automatic run_to_halt(input int bound, input int exp_run, output int ack_cyc,
                             output int halt_cyc, output bit unstable, output int bad_runs);
    bit          prev_req = 1'b0;
    logic [15:0] prev_addr = '0;
    int          run = 0;
    ack_cyc = 0; halt_cyc = 0; unstable = 1'b0; bad_runs = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (halted) begin
        halt_cyc = cyc;
        return;
      end
      if (mem_req) begin
        if (prev_req && mem_addr != prev_addr) unstable = 1'b1;
        run++;
        if (mem_ack) begin
          ack_cyc = cyc;
          if (exp_run != 0 && run != exp_run) bad_runs++;
          run = 0;
        end
      end else begin
        run = 0;
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
    end
    chk("halt_timeout", 32'(halted), 32'd1);
  endtask

  task automatic check_halt_hold(input logic [15:0] addr);
    int bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req || reg_enable != 0 || mem_addr != addr || !halted || retire) bad++;
    end
    chk("halt_hold_bad_cycles", bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  ack_c, halt_c, bad_runs, t;
    bit  unstable;
    for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;

    // ---- Phase 1: zero-wait program, all instruction classes ----
    mem[0] = 16'h5102; mem[1] = 16'h0321; mem[2] = 16'h0000;
    mem[3] = 16'hF123; mem[4] = 16'hFFFF;
    push(16'd0, 16'h0002, 4'd1, 4'd0, 1'b1, 16'h5102, 1'b0, 0);
    push(16'd1, 16'h0008, 4'd3, 4'd1, 1'b0, 16'h0321, 1'b0, 3);
    push(16'd2, 16'h0000, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 3);
    push(16'd3, 16'h0000, 4'd1, 4'd3, 1'b0, 16'hF123, 1'b1, 3);
    do_reset("p1");
    run_to_halt(200, 1, ack_c, halt_c, unstable, bad_runs);
    chk("p1_halt_latency", halt_c - ack_c, 2);
    chk("p1_sb_drained", sb.size(), 0);
    check_halt_hold(16'd4);

    // ---- Phase 2: 5-cycle ack delay, spurious acks outside FETCH ----
    mem[0] = 16'h1A55; mem[1] = 16'h0B2C; mem[2] = 16'hFFFF;
    ack_delay = 5; spurious = 1'b1;
    push(16'd0, 16'h0400, 4'hA, 4'h0, 1'b1, 16'h1A55, 1'b0, 0);
    push(16'd1, 16'h0800, 4'hB, 4'hC, 1'b0, 16'h0B2C, 1'b0, 8);
    do_reset("p2");
    run_to_halt(300, 6, ack_c, halt_c, unstable, bad_runs);
    chk("p2_addr_stable", 32'(unstable), 0);
    chk("p2_wait_runs", bad_runs, 0);
    chk("p2_halt_latency", halt_c - ack_c, 2);
    chk("p2_sb_drained", sb.size(), 0);
    check_halt_hold(16'd2);

    // ---- Phase 3: reset with request outstanding and a same-cycle ack ----
    mem[0] = 16'h5102; mem[1] = 16'hFFFF;
    ack_delay = 0; spurious = 1'b0;
    do_reset("p3a");
    t = 0;
    while (!mem_req && t < 10) begin @(negedge clk); t++; end
    chk("p3_req_seen", mem_req, 1);
    #2;
    reset = 1'b1; ovr_ack = 1'b1; ovr_rdata = 16'h0321;
    @(negedge clk);
    chk("p3_rst_req",    mem_req, 0);
    chk("p3_rst_ctrl",   {reg_enable, mux_a, mux_b, 3'b0, mux_c}, 0);
    chk("p3_rst_alu",    alu_control, 0);
    chk("p3_rst_pulses", {retire, illegal, halted}, 0);
    @(negedge clk);       // late ack still held during reset
    chk("p3_rst_req2", mem_req, 0);
    ovr_ack = 1'b0;
    reset = 1'b0;
    push(16'd0, 16'h0002, 4'd1, 4'd0, 1'b1, 16'h5102, 1'b0, 0);
    t = 0;
    while (!mem_req && t < 10) begin @(negedge clk); t++; end
    chk("p3_first_fetch_addr", mem_addr, 0);
    run_to_halt(200, 1, ack_c, halt_c, unstable, bad_runs);
    chk("p3_sb_drained", sb.size(), 0);
    chk("p3_halt_addr", mem_addr, 1);

    // ---- Phase 4: 4-bit PC wraps from 15 to 0 ----
    repeat (2) @(negedge clk);
    b_reset = 1'b0;
    t = 0;
    while (!b_req && t < 10) begin @(negedge clk); t++; end
    chk("p4_first_addr", b_addr, 4'hF);
    t = 0;
    while (!b_retire && t < 10) begin @(negedge clk); t++; end
    chk("p4_reg_en", b_reg_enable, 16'h0002);
    chk("p4_alu", b_alu, 16'h5102);
    chk("p4_ctrl", {b_mux_a, b_mux_b, 3'b0, b_mux_c}, {4'd1, 4'd0, 4'd1});
    t = 0;
    @(negedge clk);
    while (!b_req && t < 10) begin @(negedge clk); t++; end
    chk("p4_wrap_addr", b_addr, 4'h0);
    chk("p4_no_flags", {b_illegal, b_halted}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_fsm.md
Name: instr_decode_fsm

Overview:
Fetch/decode controller that drives the datapath from instruction words in memory instead of a hardwired state sequence. It fetches 16-bit words over a req/ack memory handshake and decodes each into the regfile one-hot write enable, operand mux selects, immediate select and ALU control word. It sits between the instruction memory and the regfile/ALU datapath, and its control outputs use the same format the datapath already consumes.

Parameters:
ADDR_W, 16, width of program counter / instruction address
BOOT_ADDR, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
mem_req  out  1  instruction fetch request
mem_addr  out  ADDR_W  fetch address (= PC)
mem_ack  in  1  fetch data valid on mem_rdata this cycle
mem_rdata  in  16  instruction word
reg_enable  out  16  one-hot regfile write enable (bit n = rN)
mux_a  out  4  operand A register select
mux_b  out  4  operand B register select
mux_c  out  1  0 = B from register, 1 = B from immediate
alu_control  out  16  instruction word presented to ALU (op/imm fields)
retire  out  1  one-cycle pulse per completed instruction
illegal  out  1  one-cycle pulse on undefined opcode
halted  out  1  high while in HALT

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All outputs are registered.
- Reset values: state=FETCH, pc=BOOT_ADDR, mem_req=0, reg_enable=0, mux_a=0, mux_b=0, mux_c=0, alu_control=0, retire=0, illegal=0, halted=0.
- Instruction fields: op=[15:12], rd=[11:8], ext=[7:4], rs=[3:0], imm=[7:0].
- Instruction classes:
  - 0x0000 = NOP.
  - 0xFFFF = HALT.
  - op=0000 (other than NOP) = register form.
  - op 0001..1110 = immediate form.
  - op=1111 (other than 0xFFFF) = illegal.
- States: FETCH, DECODE, EXECUTE, HALT.
- FETCH:
  - mem_req=1 and mem_addr=pc from the first FETCH cycle; both held until mem_ack.
  - mem_ack is sampled in the same cycle (zero-wait ack allowed).
  - On ack: IR<=mem_rdata, mem_req<=0, go to DECODE.
  - mem_ack is ignored in all other states.
- DECODE (1 cycle): loads the control registers from IR.
  - Register form: mux_a=rd, mux_b=rs, mux_c=0.
  - Immediate form: mux_a=rd, mux_b=0, mux_c=1.
  - alu_control=IR in both forms.
  - NOP and illegal: controls loaded as for register form; no write follows.
  - HALT: next state is HALT, halted<=1, no write, no retire, pc unchanged.
  - Otherwise next state is EXECUTE.
- EXECUTE (1 cycle):
  - reg_enable = 1<<rd for register/immediate forms; 0 for NOP and illegal.
  - retire=1 for every instruction, including NOP and illegal.
  - illegal=1 for illegal opcodes only.
  - pc<=pc+1, wrapping modulo 2^ADDR_W with no flag.
  - Next state is FETCH.
  - reg_enable, retire and illegal are 0 in every other cycle.
- mux_a/mux_b/mux_c/alu_control hold their DECODE values through EXECUTE and until the next DECODE. The datapath sees stable selects when reg_enable fires.
- Minimum throughput: 3 cycles per instruction (FETCH with immediate ack, DECODE, EXECUTE). Each wait cycle without ack adds 1.
- HALT: terminal state. mem_req=0, halted=1, all other outputs hold. Exit only via reset.
- Reset mid-operation (any state, including FETCH with a request outstanding):
  - The next cycle shows reset values and mem_req=0.
  - A late ack arriving during reset is ignored.
  - Fetching restarts at BOOT_ADDR the cycle after reset deasserts.
- Reset asserted in the same cycle as mem_ack: reset wins and IR is not loaded.

Test Plan:
- Reset, then memory with zero-wait ack; word[0]=0x5102 → mem_req high with mem_addr=0. Two cycles after ack, reg_enable=0x0002, mux_a=1, mux_b=0, mux_c=1, alu_control=0x5102, retire=1. Next fetch at addr 1.
- word[1]=0x0321 → EXECUTE shows reg_enable=0x0008, mux_a=3, mux_b=1, mux_c=0, alu_control=0x0321. Instruction spacing is exactly 3 cycles.
- word[2]=0x0000 (NOP), then word[3]=0xF123 → both produce reg_enable=0 and retire=1; illegal=1 only on 0xF123. pc advances to 4.
- word[4]=0xFFFF → halted=1 two cycles after ack. mem_req stays 0 for 20 cycles, reg_enable=0, mem_addr=4.
- Delay ack by 5 cycles → mem_req and mem_addr held stable throughout. Spurious ack pulses during DECODE/EXECUTE have no effect.
- Assert reset while in FETCH with req outstanding and ack arriving the same cycle → all outputs at reset values and no write. After release, first fetch is at BOOT_ADDR.
- Set ADDR_W=4 and start pc at 15 → after executing 0x5102, mem_addr wraps to 0.
